tree_node_ctrl: RTL and testbench

TREE_NODE_CTRL -- requirements
Module: tree_node_ctrl

---
 rtl/tree_node_pkg.sv | 4 +
 rtl/tree_child_port.sv | 38 +++
 rtl/tree_node_ctrl.sv | 105 ++++++++++
 tb/tb_tree_node_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tree_node_pkg.sv
// tree_node_pkg: shared FSM state encoding for the tree node controller and its child ports.
package tree_node_pkg;
    typedef enum logic [1:0] {IDLE, BCAST, WAIT, RESP} state_t;
endpackage

// File: rtl/tree_child_port.sv
// tree_child_port: per-child sent/done tracking and handshake generation.
//   clr            clears sent/done when a new parent command is accepted
//   en             this child's bit of the latched command mask
//   in_bcast       node is in BCAST, in_wait: node is in WAIT
//   cmd_valid/cmd_ready, rsp_valid/rsp_ready  child handshakes
//   rsp_hs         response transfer this cycle (folds data into the accumulator)
//   sent_n/done_n  sent/done including this cycle's handshakes
module tree_child_port (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic in_bcast,
    input  logic in_wait,
    input  logic cmd_ready,
    input  logic rsp_valid,
    output logic cmd_valid,
    output logic rsp_ready,
    output logic rsp_hs,
    output logic sent_n,
    output logic done_n
);
    logic sent, done;
    assign cmd_valid = in_bcast & en & ~sent;
    assign rsp_ready = in_wait & en & ~done;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign sent_n    = sent | (cmd_valid & cmd_ready);
    assign done_n    = done | rsp_hs;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent <= 1'b0;
            done <= 1'b0;
        end else begin
            sent <= clr ? 1'b0 : sent_n;
            done <= clr ? 1'b0 : done_n;
        end
    end
endmodule

// File: rtl/tree_node_ctrl.sv
// tree_node_ctrl: broadcasts a parent command to masked children, XOR-folds their responses, times out stragglers.
//   p_cmd_*  parent command in (valid/ready/data/mask)
//   p_rsp_*  parent response out (valid/ready/data/err/miss)
//   c_cmd_*  per-child command out, data broadcast to all
//   c_rsp_*  per-child response in, child i data at [i*DATA_W +: DATA_W]
module tree_node_ctrl
    import tree_node_pkg::*;
#(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        p_cmd_valid,
    output logic                        p_cmd_ready,
    input  logic [DATA_W-1:0]           p_cmd_data,
    input  logic [NUM_CHILD-1:0]        p_cmd_mask,
    output logic                        p_rsp_valid,
    input  logic                        p_rsp_ready,
    output logic [DATA_W-1:0]           p_rsp_data,
    output logic                        p_rsp_err,
    output logic [NUM_CHILD-1:0]        p_rsp_miss,
    output logic [NUM_CHILD-1:0]        c_cmd_valid,
    input  logic [NUM_CHILD-1:0]        c_cmd_ready,
    output logic [DATA_W-1:0]           c_cmd_data,
    input  logic [NUM_CHILD-1:0]        c_rsp_valid,
    output logic [NUM_CHILD-1:0]        c_rsp_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] c_rsp_data
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t                state, state_n;
    logic [NUM_CHILD-1:0]  mask, sent_n, done_n, rsp_hs, miss;
    logic [DATA_W-1:0]     acc, acc_n, cmd;
    logic [CW-1:0]         cnt;
    logic                  err, accept, to_hit;
    assign accept      = (state == IDLE) & p_cmd_valid;
    assign p_cmd_ready = state == IDLE;
    assign p_rsp_valid = state == RESP;
    assign p_rsp_data  = acc;
    assign p_rsp_err   = err;
    assign p_rsp_miss  = miss;
    assign c_cmd_data  = cmd;
    // cnt is 0 on the first WAIT cycle, so this fires on the TIMEOUT-th WAIT cycle
    assign to_hit      = cnt == CW'(TIMEOUT - 1);
    for (genvar i = 0; i < NUM_CHILD; i++) begin : g_ch
        tree_child_port u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (accept),
            .en       (mask[i]),
            .in_bcast (state == BCAST),
            .in_wait  (state == WAIT),
            .cmd_ready(c_cmd_ready[i]),
            .rsp_valid(c_rsp_valid[i]),
            .cmd_valid(c_cmd_valid[i]),
            .rsp_ready(c_rsp_ready[i]),
            .rsp_hs   (rsp_hs[i]),
            .sent_n   (sent_n[i]),
            .done_n   (done_n[i])
        );
    end
    always_comb begin
        acc_n = acc;
        for (int i = 0; i < NUM_CHILD; i++)
            acc_n = acc_n ^ (rsp_hs[i] ? c_rsp_data[i*DATA_W +: DATA_W] : '0);
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (p_cmd_valid) state_n = (p_cmd_mask == '0) ? RESP : BCAST;
            BCAST:   if (sent_n == mask) state_n = WAIT;
            WAIT:    if (done_n == mask || to_hit) state_n = RESP;
            RESP:    if (p_rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mask  <= '0;
            cmd   <= '0;
            acc   <= '0;
            err   <= 1'b0;
            miss  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state != WAIT) ? '0 : (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
            if (accept) begin
                cmd  <= p_cmd_data;
                mask <= p_cmd_mask;
                acc  <= '0;
                err  <= 1'b0;
                miss <= '0;
            end
            if (state == WAIT) acc <= acc_n;
            // a response landing on the timeout cycle is already in done_n
            if (state == WAIT && state_n == RESP) begin
                err  <= done_n != mask;
                miss <= mask & ~done_n;
            end
        end
    end
endmodule

// File: tb/tb_tree_node_ctrl.sv
// tb_tree_node_ctrl: directed and randomized commands checked against a cycle-count model of the node.
module tb_tree_node_ctrl;
    localparam int NC = 5;
    localparam int DW = 8;
    localparam int TO = 10;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               p_cmd_valid = 1'b0;
    logic               p_cmd_ready;
    logic [DW-1:0]      p_cmd_data = '0;
    logic [NC-1:0]      p_cmd_mask = '0;
    logic               p_rsp_valid;
    logic               p_rsp_ready = 1'b0;
    logic [DW-1:0]      p_rsp_data;
    logic               p_rsp_err;
    logic [NC-1:0]      p_rsp_miss;
    logic [NC-1:0]      c_cmd_valid;
    logic [NC-1:0]      c_cmd_ready = '0;
    logic [DW-1:0]      c_cmd_data;
    logic [NC-1:0]      c_rsp_valid = '0;
    logic [NC-1:0]      c_rsp_ready;
    logic [NC*DW-1:0]   c_rsp_data = '0;
    int checks = 0;
    int failures = 0;
    int cd[NC];
    int rd[NC];
    logic [DW-1:0] rdat[NC];

    always #5 clk = ~clk;

    tree_node_ctrl #(.NUM_CHILD(NC), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_cmd_valid(p_cmd_valid), .p_cmd_ready(p_cmd_ready), .p_cmd_data(p_cmd_data), .p_cmd_mask(p_cmd_mask),
        .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready), .p_rsp_data(p_rsp_data), .p_rsp_err(p_rsp_err),
        .p_rsp_miss(p_rsp_miss),
        .c_cmd_valid(c_cmd_valid), .c_cmd_ready(c_cmd_ready), .c_cmd_data(c_cmd_data),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_data(c_rsp_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the first cycle after the accepting edge. Child i takes the command
    // in cycle cd[i], raises its response rd[i] cycles later (rd<0: never), and holds it.
    // WAIT spans cycles B..B+TO-1; responses are taken no earlier than B.
    task automatic run_cmd(input logic [NC-1:0] m, input logic [DW-1:0] d, input int hold);
        int b, r, last, exp_r, cyc;
        int seen[NC];
        int cnt[NC];
        logic got[NC];
        logic rdn[NC];
        logic all_done, bad;
        logic [DW-1:0] exp_d;
        logic [NC-1:0] exp_miss, cmd_hs, rsp_hs;
        b = 0;
        for (int i = 0; i < NC; i++) if (m[i] && cd[i] + 1 > b) b = cd[i] + 1;
        all_done = 1'b1;
        last = 0;
        exp_d = '0;
        exp_miss = '0;
        for (int i = 0; i < NC; i++) begin
            if (!m[i]) continue;
            r = (cd[i] + 1 + rd[i] > b) ? cd[i] + 1 + rd[i] : b;
            if (rd[i] >= 0 && r <= b + TO - 1) begin
                exp_d ^= rdat[i];
                if (r > last) last = r;
            end else begin
                all_done = 1'b0;
                exp_miss[i] = 1'b1;
            end
        end
        exp_r = (m == '0) ? 0 : all_done ? last + 1 : b + TO;
        for (int i = 0; i < NC; i++) begin
            c_rsp_data[i*DW +: DW] = rdat[i];
            seen[i] = 0;
            cnt[i] = 0;
            got[i] = 1'b0;
            rdn[i] = 1'b0;
        end
        chk("idle_cmd_ready", {31'b0, p_cmd_ready}, 1);
        p_cmd_valid = 1'b1;
        p_cmd_data = d;
        p_cmd_mask = m;
        @(posedge clk);
        #1;
        p_cmd_valid = 1'b0;
        p_cmd_data = DW'($urandom);
        p_cmd_mask = NC'($urandom);
        chk("c_cmd_data", {24'b0, c_cmd_data}, {24'b0, d});
        cyc = 0;
        bad = 1'b0;
        while (!p_rsp_valid && cyc < 100) begin
            for (int i = 0; i < NC; i++) begin
                c_cmd_ready[i] = c_cmd_valid[i] && seen[i] >= cd[i];
                c_rsp_valid[i] = got[i] && !rdn[i] && rd[i] >= 0 && cnt[i] >= rd[i];
            end
            bad |= ((c_cmd_valid & ~m) != '0) || ((c_rsp_ready & ~m) != '0) || p_cmd_ready;
            cmd_hs = c_cmd_valid & c_cmd_ready;
            rsp_hs = c_rsp_valid & c_rsp_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (got[i]) cnt[i]++;
                if (cmd_hs[i]) got[i] = 1'b1;
                else if (c_cmd_valid[i]) seen[i]++;
                if (rsp_hs[i]) rdn[i] = 1'b1;
            end
            cyc++;
        end
        c_cmd_ready = '0;
        chk("rsp_latency", cyc, exp_r);
        chk("rsp_valid", {31'b0, p_rsp_valid}, 1);
        chk("rsp_data", {24'b0, p_rsp_data}, {24'b0, exp_d});
        chk("rsp_err", {31'b0, p_rsp_err}, {31'b0, !all_done});
        chk("rsp_miss", {27'b0, p_rsp_miss}, {27'b0, exp_miss});
        chk("no_stray_valid_ready", {31'b0, bad}, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'b0, p_rsp_valid}, 1);
            chk("hold_cmd_ready", {31'b0, p_cmd_ready}, 0);
            chk("hold_data", {23'b0, p_rsp_err, p_rsp_data}, {23'b0, !all_done, exp_d});
            chk("hold_miss", {27'b0, p_rsp_miss}, {27'b0, exp_miss});
        end
        c_rsp_valid = '0;
        p_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        p_rsp_ready = 1'b0;
        chk("back_to_idle", {30'b0, p_cmd_ready, p_rsp_valid}, 2);
    endtask

    task automatic set_children(input int cdly, input int rdly);
        for (int i = 0; i < NC; i++) begin
            cd[i] = cdly;
            rd[i] = rdly;
            rdat[i] = DW'(1 << i);
        end
    endtask

    initial begin
        #12;
        chk("reset_state", {16'b0, p_cmd_ready, p_rsp_valid, c_cmd_valid, c_rsp_ready, p_rsp_err, 3'b0},
            {16'b0, 1'b1, 1'b0, 5'b0, 5'b0, 1'b0, 3'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_children(0, 0);
        run_cmd(5'h1F, 8'hA5, 0);
        cd[2] = 3;
        run_cmd(5'b00101, 8'h3C, 0);
        set_children(0, 0);
        rd[3] = -1;
        run_cmd(5'h1F, 8'h11, 0);
        run_cmd(5'h00, 8'h77, 0);
        set_children(1, 2);
        run_cmd(5'h16, 8'h5A, 5);
        p_cmd_valid = 1'b1;
        p_cmd_data = 8'hC3;
        p_cmd_mask = 5'h1F;
        @(posedge clk);
        #1;
        p_cmd_valid = 1'b0;
        c_cmd_ready = '1;
        @(posedge clk);
        #1;
        c_cmd_ready = '0;
        @(posedge clk);
        #1;
        chk("pre_reset_wait", {27'b0, c_rsp_ready}, 32'h1F);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {15'b0, p_cmd_ready, p_rsp_valid, c_cmd_valid, c_rsp_ready, c_cmd_data},
            {15'b0, 1'b1, 1'b0, 5'b0, 5'b0, 8'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("no_rsp_after_reset", {31'b0, p_rsp_valid}, 0);
        set_children(0, 0);
        run_cmd(5'h1F, 8'h99, 0);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NC; i++) begin
                cd[i] = int'($urandom_range(0, 3));
                rd[i] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
                rdat[i] = DW'($urandom);
            end
            run_cmd(NC'($urandom), DW'($urandom), int'($urandom_range(0, 2)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
